// File: rtl/drive_command_conditioner_if.sv
// Signal bundle between the semi-auto front end and its environment.
// The master side drives buttons, detectors and enable; the slave side is the conditioner.
interface drive_command_conditioner_if;
    logic enable;
    logic go_straight_btn;
    logic turn_left_btn;
    logic turn_right_btn;
    logic front_detector_raw;
    logic back_detector_raw;
    logic left_detector_raw;
    logic right_detector_raw;
    logic go_straight_command;
    logic turn_left_command;
    logic turn_right_command;
    logic cmd_conflict;
    logic front_detector;
    logic back_detector;
    logic left_detector;
    logic right_detector;

    modport master (
        output enable,
        output go_straight_btn,
        output turn_left_btn,
        output turn_right_btn,
        output front_detector_raw,
        output back_detector_raw,
        output left_detector_raw,
        output right_detector_raw,
        input  go_straight_command,
        input  turn_left_command,
        input  turn_right_command,
        input  cmd_conflict,
        input  front_detector,
        input  back_detector,
        input  left_detector,
        input  right_detector
    );

    modport slave (
        input  enable,
        input  go_straight_btn,
        input  turn_left_btn,
        input  turn_right_btn,
        input  front_detector_raw,
        input  back_detector_raw,
        input  left_detector_raw,
        input  right_detector_raw,
        output go_straight_command,
        output turn_left_command,
        output turn_right_command,
        output cmd_conflict,
        output front_detector,
        output back_detector,
        output left_detector,
        output right_detector
    );
endinterface

// File: rtl/drive_command_conditioner.sv
// Driver button / obstacle detector front end: 2-flop sync, debounce, one-hot command pulses.
// Define DET_FILTER_EN to also debounce the detectors over DET_FILTER_CYCLES.
module drive_command_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 2000000,
    parameter int CNT_W             = 32,
    parameter int DET_FILTER_CYCLES = 1000
) (
    input logic clk,
    input logic rst_n,
    drive_command_conditioner_if.slave bus
);

    localparam int NB = 3;
    localparam int ND = 4;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button bit order: 0 = go_straight, 1 = turn_left, 2 = turn_right.
    // Detector bit order: 0 = front, 1 = back, 2 = left, 3 = right.
    logic [NB-1:0]    btn_raw;
    logic [ND-1:0]    det_raw;
    logic [NB-1:0]    btn_meta;
    logic [NB-1:0]    btn_sync;
    logic [ND-1:0]    det_meta;
    logic [ND-1:0]    det_sync;
    logic [NB-1:0]    btn_stable;
    logic [CNT_W-1:0] btn_cnt [NB];
    logic [NB-1:0]    btn_stable_q;
    logic [NB-1:0]    btn_rise_r;
    logic [NB-1:0]    cmd_q;
    logic             conflict_q;
    logic [ND-1:0]    det_out;

    logic any_rise;
    logic one_rise;
    logic others_held;
    logic grant;
    logic reject;

    if (DEBOUNCE_CYCLES < 1 || (CNT_W < 32 && DEBOUNCE_CYCLES - 1 >= (1 << CNT_W))) begin : g_bad_debounce
        $error("drive_command_conditioner: CNT_W cannot hold DEBOUNCE_CYCLES-1");
    end

    if (DET_FILTER_CYCLES < 1 || (CNT_W < 32 && DET_FILTER_CYCLES - 1 >= (1 << CNT_W))) begin : g_bad_det_window
        $error("drive_command_conditioner: CNT_W cannot hold DET_FILTER_CYCLES-1");
    end

    assign btn_raw = {bus.turn_right_btn, bus.turn_left_btn, bus.go_straight_btn};
    assign det_raw = {bus.right_detector_raw, bus.left_detector_raw,
                      bus.back_detector_raw, bus.front_detector_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
            det_meta <= '0;
            det_sync <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            det_meta <= det_raw;
            det_sync <= det_meta;
        end
    end

    // The counter only runs while the synchronised level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the window from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_stable <= '0;
            for (int i = 0; i < NB; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (btn_sync[i] == btn_stable[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_cnt[i] == DB_LAST) begin
                    btn_stable[i] <= btn_sync[i];
                    btn_cnt[i]    <= '0;
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_stable_q <= '0;
            btn_rise_r   <= '0;
        end else begin
            btn_stable_q <= btn_stable;
            btn_rise_r   <= btn_stable & ~btn_stable_q;
        end
    end

    // btn_stable_q is aligned with btn_rise_r, so a button counts as already held
    // when its level is up without a rise in the same cycle.
    always_comb begin
        any_rise    = |btn_rise_r;
        one_rise    = any_rise && ((btn_rise_r & (btn_rise_r - 3'd1)) == 3'd0);
        others_held = |(btn_stable_q & ~btn_rise_r);
        grant       = bus.enable && one_rise && !others_held;
        reject      = bus.enable && any_rise && !(one_rise && !others_held);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            cmd_q      <= grant ? btn_rise_r : '0;
            conflict_q <= reject;
        end
    end

`ifdef DET_FILTER_EN
    localparam logic [CNT_W-1:0] DET_LAST = CNT_W'(DET_FILTER_CYCLES - 1);

    logic [ND-1:0]    det_stable;
    logic [CNT_W-1:0] det_cnt [ND];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_stable <= '0;
            for (int i = 0; i < ND; i++) begin
                det_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ND; i++) begin
                if (det_sync[i] == det_stable[i]) begin
                    det_cnt[i] <= '0;
                end else if (det_cnt[i] == DET_LAST) begin
                    det_stable[i] <= det_sync[i];
                    det_cnt[i]    <= '0;
                end else begin
                    det_cnt[i] <= det_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign det_out = det_stable;
`else
    assign det_out = det_sync;
`endif

    assign bus.go_straight_command = cmd_q[0];
    assign bus.turn_left_command   = cmd_q[1];
    assign bus.turn_right_command  = cmd_q[2];
    assign bus.cmd_conflict        = conflict_q;
    assign bus.front_detector      = det_out[0];
    assign bus.back_detector       = det_out[1];
    assign bus.left_detector       = det_out[2];
    assign bus.right_detector      = det_out[3];

endmodule

// File: tb/tb_drive_command_conditioner.sv
// Directed bench for drive_command_conditioner with DEBOUNCE_CYCLES=4, DET_FILTER_CYCLES=3.
// Build with DET_FILTER_EN defined to exercise the detector filter expectations.
module tb_drive_command_conditioner;

    localparam int DEB  = 4;
    localparam int DETF = 3;
`ifdef DET_FILTER_EN
    localparam int DET_LAT = 2 + DETF;
`else
    localparam int DET_LAT = 2;
`endif
    localparam int NVEC = 26;

    // Output word layout: {right,left,straight commands, conflict, right,left,back,front detectors}
    typedef struct packed {
        logic       en;
        logic [2:0] btn;
        logic [3:0] det;
        logic [2:0] exp_cmd;
        logic       exp_conf;
        logic [3:0] exp_det;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    drive_command_conditioner_if bus ();

    drive_command_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .CNT_W            (32),
        .DET_FILTER_CYCLES(DETF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_straight, n_left, n_right, n_conf;
    int n_overlap = 0;
    vec_t vecs [NVEC];

    function automatic logic [7:0] outVec();
        return {bus.turn_right_command, bus.turn_left_command, bus.go_straight_command,
                bus.cmd_conflict, bus.right_detector, bus.left_detector,
                bus.back_detector, bus.front_detector};
    endfunction

    task automatic applyStimulus(input logic en, input logic [2:0] btn, input logic [3:0] det);
        bus.enable             = en;
        bus.go_straight_btn    = btn[0];
        bus.turn_left_btn      = btn[1];
        bus.turn_right_btn     = btn[2];
        bus.front_detector_raw = det[0];
        bus.back_detector_raw  = det[1];
        bus.left_detector_raw  = det[2];
        bus.right_detector_raw = det[3];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearWatch();
        n_straight = 0;
        n_left     = 0;
        n_right    = 0;
        n_conf     = 0;
    endtask

    // One clock: inputs are sampled on the rising edge, outputs read on the falling edge.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        if (bus.go_straight_command) n_straight++;
        if (bus.turn_left_command)   n_left++;
        if (bus.turn_right_command)  n_right++;
        if (bus.cmd_conflict)        n_conf++;
        if (int'(bus.go_straight_command) + int'(bus.turn_left_command) + int'(bus.turn_right_command) > 1)
            n_overlap++;
    endtask

    initial begin
        for (int i = 0; i < NVEC; i++) begin
            vecs[i].en       = 1'b1;
            vecs[i].btn      = (i >= 1 && i <= 20) ? 3'b010 : 3'b000;
            vecs[i].det      = {(i >= 2) ? 1'b1 : 1'b0, 1'b0, (i >= 10 && i <= 17) ? 1'b1 : 1'b0, 1'b0};
            vecs[i].exp_cmd  = (i == 8) ? 3'b010 : 3'b000;
            vecs[i].exp_conf = 1'b0;
            vecs[i].exp_det  = {(i >= 2 + DET_LAT - 1) ? 1'b1 : 1'b0, 1'b0,
                                (i >= 10 + DET_LAT - 1 && i <= 18 + DET_LAT - 2) ? 1'b1 : 1'b0, 1'b0};
        end

        clearWatch();
        applyStimulus(1'b1, 3'b111, 4'hF);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 32'(outVec()), 32'h0);

        applyStimulus(1'b1, 3'b000, 4'h0);
        rst_n = 1'b1;
        repeat (4) stepCycle();

        // Held turn_left: pulse 8 edges after vector 1; detectors follow with DET_LAT.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].en, vecs[i].btn, vecs[i].det);
            stepCycle();
            checkOutput($sformatf("vec%0d", i), 32'(outVec()),
                        32'({vecs[i].exp_cmd, vecs[i].exp_conf, vecs[i].exp_det}));
        end
        applyStimulus(1'b1, 3'b000, 4'h0);
        repeat (10) stepCycle();

        clearWatch();
        applyStimulus(1'b1, 3'b001, 4'h0);
        repeat (3) stepCycle();
        applyStimulus(1'b1, 3'b000, 4'h0);
        repeat (15) stepCycle();
        checkOutput("glitch3_straight", 32'(n_straight), 32'd0);
        checkOutput("glitch3_conflict", 32'(n_conf), 32'd0);

        clearWatch();
        applyStimulus(1'b1, 3'b001, 4'h0);
        repeat (4) stepCycle();
        applyStimulus(1'b1, 3'b000, 4'h0);
        repeat (15) stepCycle();
        checkOutput("press4_straight", 32'(n_straight), 32'd1);
        checkOutput("press4_others", 32'(n_left + n_right + n_conf), 32'd0);

        clearWatch();
        applyStimulus(1'b1, 3'b101, 4'h0);
        repeat (10) stepCycle();
        applyStimulus(1'b1, 3'b000, 4'h0);
        repeat (15) stepCycle();
        checkOutput("dual_commands", 32'(n_straight + n_left + n_right), 32'd0);
        checkOutput("dual_conflict", 32'(n_conf), 32'd1);

        clearWatch();
        applyStimulus(1'b0, 3'b100, 4'h0);
        repeat (10) stepCycle();
        applyStimulus(1'b1, 3'b100, 4'h0);
        repeat (10) stepCycle();
        checkOutput("enable_held_right", 32'(n_right), 32'd0);
        checkOutput("enable_held_conflict", 32'(n_conf), 32'd0);
        applyStimulus(1'b1, 3'b000, 4'h0);
        repeat (10) stepCycle();
        applyStimulus(1'b1, 3'b100, 4'h0);
        repeat (10) stepCycle();
        applyStimulus(1'b1, 3'b000, 4'h0);
        repeat (10) stepCycle();
        checkOutput("repress_right", 32'(n_right), 32'd1);
        checkOutput("repress_others", 32'(n_straight + n_left + n_conf), 32'd0);

        // Reset mid-debounce with a detector high so the cleared state is observable.
        applyStimulus(1'b1, 3'b000, 4'b1000);
        repeat (8) stepCycle();
        applyStimulus(1'b1, 3'b010, 4'b1000);
        repeat (4) stepCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async", 32'(outVec()), 32'h0);
        for (int k = 0; k < 2; k++) begin
            stepCycle();
            checkOutput($sformatf("reset_hold%0d", k), 32'(outVec()), 32'h0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            stepCycle();
            checkOutput($sformatf("reset_wait%0d", k), 32'(outVec() >> 4), 32'h0);
        end
        stepCycle();
        checkOutput("reset_pulse", 32'(outVec() >> 4), 32'b0100);
        stepCycle();
        checkOutput("reset_pulse_end", 32'(outVec() >> 4), 32'h0);
        applyStimulus(1'b1, 3'b000, 4'h0);
        repeat (10) stepCycle();

`ifdef DET_FILTER_EN
        applyStimulus(1'b1, 3'b000, 4'b0001);
        repeat (2) stepCycle();
        applyStimulus(1'b1, 3'b000, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            checkOutput($sformatf("front_glitch%0d", k), 32'(bus.front_detector), 32'd0);
        end
`endif
        applyStimulus(1'b1, 3'b000, 4'b0001);
        for (int k = 1; k <= DET_LAT + 1; k++) begin
            stepCycle();
            checkOutput($sformatf("front_edge%0d", k), 32'(bus.front_detector), 32'(k >= DET_LAT));
        end

        checkOutput("mutual_exclusion", 32'(n_overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
